// File: rtl/im_loader_if.sv
// Byte-stream handshake plus instruction-memory write port of the program loader.
interface im_loader_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) ();
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_wdata;

  // Source of the byte stream and consumer of memory writes
  modport master (
    output byte_valid, byte_data,
    input  byte_ready, im_we, im_addr, im_wdata
  );

  // Loader side
  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/im_loader.sv
// Program loader: packs a length-prefixed byte stream into 16-bit words and writes them to instruction memory.
// Define IM_LOADER_CHECKSUM_EN to require and verify a trailing XOR checksum byte.
module im_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  im_loader_if.slave    bus,
  output logic          core_rst,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [ADDR_W:0] words_loaded
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned REM_W = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_HI,
    S_LO,
    S_WR,
`ifdef IM_LOADER_CHECKSUM_EN
    S_CHK,
    S_ERR,
`endif
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic             ready_n, busy_n;
  logic             accept;
  logic [REM_W-1:0] remaining;
  logic [7:0]       hi_byte;

`ifdef IM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
`endif

  assign accept = bus.byte_valid & bus.byte_ready;

  // Next state; registered outputs are decoded from the next state so they line up with it
  always_comb begin
    state_n = state;
    ready_n = 1'b0;
    busy_n  = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (start) state_n = S_LEN;
      S_LEN:          if (accept) state_n = S_HI;
      S_HI:           if (accept) state_n = S_LO;
      S_LO:           if (accept) state_n = S_WR;
`ifdef IM_LOADER_CHECKSUM_EN
      S_WR:           state_n = (remaining != REM_W'(1)) ? S_HI : S_CHK;
      S_CHK:          if (accept) state_n = (bus.byte_data == csum) ? S_DONE : S_ERR;
      S_ERR:          if (start) state_n = S_LEN;
`else
      S_WR:           state_n = (remaining != REM_W'(1)) ? S_HI : S_DONE;
`endif
      default:        state_n = S_IDLE;
    endcase
    ready_n = (state_n == S_LEN) || (state_n == S_HI) || (state_n == S_LO);
`ifdef IM_LOADER_CHECKSUM_EN
    ready_n = ready_n || (state_n == S_CHK);
`endif
    busy_n  = ready_n || (state_n == S_WR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      bus.byte_ready <= 1'b0;
      bus.im_we      <= 1'b0;
      bus.im_addr    <= ADDR_W'(BASE_ADDR);
      bus.im_wdata   <= '0;
      core_rst       <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      words_loaded   <= '0;
      remaining      <= '0;
      hi_byte        <= '0;
    end else begin
      state          <= state_n;
      bus.byte_ready <= ready_n;
      bus.im_we      <= (state_n == S_WR);
      core_rst       <= (state_n != S_DONE);
      busy           <= busy_n;
      done           <= (state_n == S_DONE);
      if (accept) begin
        case (state)
          S_LEN: begin
            remaining    <= (bus.byte_data == 8'h00) ? REM_W'(256) : REM_W'(bus.byte_data);
            bus.im_addr  <= ADDR_W'(BASE_ADDR);
            words_loaded <= '0;
          end
          S_HI:    hi_byte      <= bus.byte_data;
          S_LO:    bus.im_wdata <= DATA_W'({hi_byte, bus.byte_data});
          default: ;
        endcase
      end
      // Advance after the write cycle; the address wraps modulo the memory depth
      if (state == S_WR) begin
        bus.im_addr  <= bus.im_addr + ADDR_W'(1);
        words_loaded <= words_loaded + CNT_W'(1);
        remaining    <= remaining - REM_W'(1);
      end
    end
  end

`ifdef IM_LOADER_CHECKSUM_EN
  // XOR of data bytes only; length and checksum bytes are excluded
  always_ff @(posedge clk) begin
    if (rst) begin
      csum <= '0;
      err  <= 1'b0;
    end else begin
      err <= (state_n == S_ERR);
      if (accept) begin
        case (state)
          S_LEN:      csum <= '0;
          S_HI, S_LO: csum <= csum ^ bus.byte_data;
          default:    ;
        endcase
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: expected writes queued by stimulus, checked by a negedge monitor.
module tb_im_loader;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;
`ifdef IM_LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            core_rst, busy, done, err;
  logic [ADDR_W:0] words_loaded;

  im_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  im_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(0)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .core_rst     (core_rst),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [23:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && bus.im_we === 1'b1) begin
      chk("ready_in_wr", 32'(bus.byte_ready), 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {8'h0, bus.im_addr, bus.im_wdata}, 32'hFFFFFFFF);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        chk("write", {8'h0, bus.im_addr, bus.im_wdata}, {8'h0, e});
      end
    end
  end

  task automatic expect_write(input logic [7:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int i = 0; i < gap; i++) begin
      bus.byte_valid = 1'b0;
      @(negedge clk);
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    t = 0;
    while (bus.byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (bus.byte_ready !== 1'b1) chk("byte_timeout", 32'(t), 32'd0);
    @(negedge clk);
  endtask

  task automatic send_stream(input logic [7:0] s[$], input int gapmax);
    foreach (s[i]) send_byte(s[i], (gapmax > 0) ? int'($urandom_range(1, gapmax)) : 0);
    bus.byte_valid = 1'b0;
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (done !== 1'b1 && err !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (done !== 1'b1 && err !== 1'b1) chk("end_timeout", 32'(t), 32'd0);
  endtask

  task automatic check_status(input string tag, input logic e_done, input logic e_err,
                              input logic [8:0] e_words, input logic [7:0] e_addr);
    chk({tag, "_done"}, 32'(done), 32'(e_done));
    chk({tag, "_err"}, 32'(err), 32'(e_err));
    chk({tag, "_core_rst"}, 32'(core_rst), 32'(!e_done));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'(e_words));
    chk({tag, "_addr"}, 32'(bus.im_addr), 32'(e_addr));
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
    chk({tag, "_we"}, 32'(bus.im_we), 32'd0);
    chk({tag, "_addr"}, 32'(bus.im_addr), 32'd0);
    chk({tag, "_core_rst"}, 32'(core_rst), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic load_basic(input string tag, input int gapmax);
    logic [7:0] s[$];
    s = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    if (CK) s.push_back(8'h40);
    expect_write(8'h00, 16'h1234);
    expect_write(8'h01, 16'hABCD);
    pulse_start();
    send_stream(s, gapmax);
    wait_end();
    check_status(tag, 1'b1, 1'b0, 9'd2, 8'h02);
  endtask

  initial begin
    logic [7:0] s[$];
    rst = 1'b1;
    start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    chk("reset_wdata", 32'(bus.im_wdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Two-word load, valid held high throughout (including the write cycles)
    load_basic("basic", 0);

`ifdef IM_LOADER_CHECKSUM_EN
    // Bad checksum: writes still happen, load ends in error
    s = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    expect_write(8'h00, 16'h1234);
    expect_write(8'h01, 16'hABCD);
    pulse_start();
    send_stream(s, 0);
    wait_end();
    check_status("badsum", 1'b0, 1'b1, 9'd2, 8'h02);
`endif

    // Length 0 means 256 words; address wraps back to 0
    s = '{8'h00};
    for (int k = 0; k < 256; k++) begin
      s.push_back(8'h00);
      s.push_back(8'(k));
      expect_write(8'(k), {8'h00, 8'(k)});
    end
    if (CK) s.push_back(8'h00);
    pulse_start();
    send_stream(s, 0);
    wait_end();
    check_status("full", 1'b1, 1'b0, 9'd256, 8'h00);

    // Random 1-3 cycle gaps between bytes
    load_basic("gaps", 3);

    // Reset after the first word has been written
    s = '{8'h02, 8'h12, 8'h34};
    expect_write(8'h00, 16'h1234);
    pulse_start();
    send_stream(s, 0);
    @(negedge clk);
    chk("midload_words", 32'(words_loaded), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    @(negedge clk);
    load_basic("after_rst", 0);

    // start while in LO is ignored
    expect_write(8'h00, 16'h1234);
    expect_write(8'h01, 16'hABCD);
    pulse_start();
    send_byte(8'h02, 0);
    send_byte(8'h12, 0);
    start = 1'b1;
    send_byte(8'h34, 0);
    start = 1'b0;
    s = '{8'hAB, 8'hCD};
    if (CK) s.push_back(8'h40);
    send_stream(s, 0);
    wait_end();
    check_status("start_busy", 1'b1, 1'b0, 9'd2, 8'h02);

    // Single word 0xBEEF; checksum 0xBE^0xEF = 0x51 only when enabled
    s = '{8'h01, 8'hBE, 8'hEF};
    if (CK) s.push_back(8'h51);
    expect_write(8'h00, 16'hBEEF);
    pulse_start();
    send_stream(s, 0);
    wait_end();
    check_status("beef", 1'b1, 1'b0, 9'd1, 8'h01);
    // An extra byte after DONE must not be consumed
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h99;
    @(negedge clk);
    chk("done_ready", 32'(bus.byte_ready), 32'd0);
    bus.byte_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
